// File: rtl/multi_pulse_she_pwm.sv
// N-pulse selective-harmonic-elimination PWM: reflecting triangle counter, double-buffered
// angle bank, parity-based pulse target and dead-time insertion on polarity reversal.
module multi_pulse_she_pwm #(
    parameter int  PHASE_W = 28,
    parameter int  INC_W   = 18,
    parameter int  TRI_W   = 15,
    parameter int  NPULSE  = 5,
    parameter int  DEAD    = 20,
    localparam int AW      = (NPULSE > 1) ? $clog2(NPULSE) : 1
) (
    input  logic              clk100MHz,
    input  logic              rst,
    input  logic              en,
    input  logic [INC_W-1:0]  increment,
    input  logic              ang_we,
    input  logic [AW-1:0]     ang_addr,
    input  logic [TRI_W-1:0]  ang_data,
    input  logic              commit,
    output logic [1:0]        pwm_drive,
    output logic [1:0]        quadrant,
    output logic              cycle_start,
    output logic              bank_swapped,
    output logic [TRI_W-1:0]  tri_o
);
    localparam int SHIFT = PHASE_W - TRI_W;
    localparam int DW    = (DEAD > 0) ? $clog2(DEAD + 1) : 1;
    localparam logic [PHASE_W:0] TOP_X  = {2'b01, {(PHASE_W-1){1'b0}}};
    localparam logic [PHASE_W:0] TOP2_X = {1'b1, {PHASE_W{1'b0}}};

    typedef enum logic {ST_RUN, ST_DEAD} dead_state_e;

    logic [PHASE_W:0]  count_q, count_d, inc_x, sum_x;
    logic [1:0]        quadrant_q, quadrant_d;
    logic              wrap, do_swap;
    logic [TRI_W-1:0]  shadow_q [NPULSE];
    logic [TRI_W-1:0]  active_q [NPULSE];
    logic              pending_q, cycle_q, swap_q;
    logic [NPULSE-1:0] hit, cmp_q;
    logic              pol1_q, ton_q, tpol_q;
    logic [1:0]        tgt, prior_drive, pwm_q, pwm_d;
    dead_state_e       st_q, st_d;
    logic [DW-1:0]     dcnt_q, dcnt_d;
    logic              prior_q, prior_d;

    assign inc_x = {{(PHASE_W+1-INC_W){1'b0}}, increment};
    assign sum_x = count_q + inc_x;
    assign tri_o = count_q[PHASE_W-1:SHIFT];

    // quadrant[0] doubles as the down flag: every reflection toggles it and bumps the quadrant
    always_comb begin
        count_d    = count_q;
        quadrant_d = quadrant_q;
        wrap       = 1'b0;
        if (!quadrant_q[0]) begin
            if (sum_x >= TOP_X) begin
                count_d    = TOP2_X - sum_x;
                quadrant_d = quadrant_q + 2'd1;
            end else begin
                count_d = sum_x;
            end
        end else if (count_q <= inc_x) begin
            count_d    = inc_x - count_q;
            quadrant_d = quadrant_q + 2'd1;
            wrap       = (quadrant_q == 2'd3);
        end else begin
            count_d = count_q - inc_x;
        end
    end

    assign do_swap = wrap & (pending_q | commit);

    for (genvar gi = 0; gi < NPULSE; gi++) begin : g_cmp
        assign hit[gi] = (active_q[gi] <= tri_o);
    end

    always_ff @(posedge clk100MHz or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            quadrant_q <= '0;
            pending_q  <= 1'b0;
            cycle_q    <= 1'b0;
            swap_q     <= 1'b0;
            cmp_q      <= '0;
            pol1_q     <= 1'b0;
            ton_q      <= 1'b0;
            tpol_q     <= 1'b0;
            for (int i = 0; i < NPULSE; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NPULSE; i++) begin
                if (ang_we && ang_addr == AW'(i)) begin
                    shadow_q[i] <= ang_data;
                end
            end
            if (!en) begin
                count_q    <= '0;
                quadrant_q <= '0;
                cycle_q    <= 1'b0;
                swap_q     <= 1'b0;
                cmp_q      <= '0;
                pol1_q     <= 1'b0;
                ton_q      <= 1'b0;
                tpol_q     <= 1'b0;
                pending_q  <= pending_q | commit;
            end else begin
                count_q    <= count_d;
                quadrant_q <= quadrant_d;
                cycle_q    <= wrap;
                swap_q     <= do_swap;
                cmp_q      <= hit;
                pol1_q     <= quadrant_q[1];
                ton_q      <= ^cmp_q;
                tpol_q     <= pol1_q;
                // the active bank takes the pre-write shadow, so a same-clock ang_we lands only in shadow
                if (do_swap) begin
                    for (int i = 0; i < NPULSE; i++) begin
                        active_q[i] <= shadow_q[i];
                    end
                    pending_q <= 1'b0;
                end else begin
                    pending_q <= pending_q | commit;
                end
            end
        end
    end

    assign tgt         = ton_q ? (tpol_q ? 2'b01 : 2'b10) : 2'b00;
    assign prior_drive = prior_q ? 2'b01 : 2'b10;

    always_ff @(posedge clk100MHz or posedge rst) begin
        if (rst) begin
            st_q    <= ST_RUN;
            dcnt_q  <= '0;
            prior_q <= 1'b0;
            pwm_q   <= 2'b00;
        end else begin
            st_q    <= st_d;
            dcnt_q  <= dcnt_d;
            prior_q <= prior_d;
            pwm_q   <= pwm_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        dcnt_d  = dcnt_q;
        prior_d = prior_q;
        pwm_d   = pwm_q;
        if (!en) begin
            st_d    = ST_RUN;
            dcnt_d  = '0;
            prior_d = 1'b0;
            pwm_d   = 2'b00;
        end else if (st_q == ST_RUN) begin
            if ((pwm_q != 2'b00) && (tgt != 2'b00) && (tgt != pwm_q) && (DEAD > 0)) begin
                st_d    = ST_DEAD;
                dcnt_d  = DW'(DEAD);
                prior_d = pwm_q[0];
                pwm_d   = 2'b00;
            end else begin
                pwm_d = tgt;
            end
        end else begin
            // going back to the polarity we left cancels the gap; otherwise the latest target wins at expiry
            if (tgt == prior_drive) begin
                st_d   = ST_RUN;
                dcnt_d = '0;
                pwm_d  = prior_drive;
            end else if (dcnt_q == DW'(1)) begin
                st_d   = ST_RUN;
                dcnt_d = '0;
                pwm_d  = tgt;
            end else begin
                dcnt_d = dcnt_q - DW'(1);
                pwm_d  = 2'b00;
            end
        end
    end

    assign pwm_drive    = pwm_q;
    assign quadrant     = quadrant_q;
    assign cycle_start  = cycle_q;
    assign bank_swapped = swap_q;

endmodule

// File: tb/tb_multi_pulse_she_pwm.sv
// Self-checking bench for multi_pulse_she_pwm: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_multi_pulse_she_pwm;
    localparam int PHASE_W = 28;
    localparam int INC_W   = 18;
    localparam int TRI_W   = 15;
    localparam int NPULSE  = 5;
    localparam int DEAD    = 20;
    localparam int AW      = 3;
    localparam longint TOP = 64'd1 << (PHASE_W - 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic [INC_W-1:0]  increment = '0;
    logic              ang_we = 1'b0;
    logic [AW-1:0]     ang_addr = '0;
    logic [TRI_W-1:0]  ang_data = '0;
    logic              commit = 1'b0;
    logic [1:0]        pwm_drive, quadrant;
    logic              cycle_start, bank_swapped;
    logic [TRI_W-1:0]  tri_o;

    multi_pulse_she_pwm #(
        .PHASE_W(PHASE_W), .INC_W(INC_W), .TRI_W(TRI_W), .NPULSE(NPULSE), .DEAD(DEAD)
    ) dut (
        .clk100MHz   (clk),
        .rst         (rst),
        .en          (en),
        .increment   (increment),
        .ang_we      (ang_we),
        .ang_addr    (ang_addr),
        .ang_data    (ang_data),
        .commit      (commit),
        .pwm_drive   (pwm_drive),
        .quadrant    (quadrant),
        .cycle_start (cycle_start),
        .bank_swapped(bank_swapped),
        .tri_o       (tri_o)
    );

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    // behavioural model state; drive codes: 0 = off, 2 = positive (10), 1 = negative (01)
    longint m_cnt = 0;
    int     m_quad = 0;
    int     m_shadow [NPULSE] = '{default: 0};
    int     m_active [NPULSE] = '{default: 0};
    bit     m_pend = 0;
    int     m_st1 = 0, m_st2 = 0, m_pwm = 0, m_hold = 0, m_prior = 0;
    bit     m_cyc = 0, m_swp = 0;

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int target_of(longint cnt, int quad);
        int tri_v;
        int k;
        tri_v = int'(cnt >> (PHASE_W - TRI_W));
        k = 0;
        for (int i = 0; i < NPULSE; i++) if (m_active[i] <= tri_v) k++;
        if (k % 2 == 0) return 0;
        return (quad >= 2) ? 1 : 2;
    endfunction

    task automatic model_edge();
        longint inc, n;
        bit wrap;
        int t2;
        if (rst) begin
            m_cnt = 0; m_quad = 0; m_pend = 0;
            m_st1 = 0; m_st2 = 0; m_pwm = 0; m_hold = 0; m_prior = 0;
            m_cyc = 0; m_swp = 0;
            for (int i = 0; i < NPULSE; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
            return;
        end
        wrap = 0;
        if (!en) begin
            m_cnt = 0; m_quad = 0; m_st1 = 0; m_st2 = 0; m_pwm = 0; m_hold = 0;
            m_cyc = 0; m_swp = 0;
            m_pend = m_pend | commit;
        end else begin
            t2 = m_st2;
            m_st2 = m_st1;
            m_st1 = target_of(m_cnt, m_quad);
            inc = longint'(increment);
            if (m_quad % 2 == 0) begin
                n = m_cnt + inc;
                if (n >= TOP) begin m_cnt = 2 * TOP - n; m_quad = (m_quad + 1) % 4; end
                else m_cnt = n;
            end else if (m_cnt <= inc) begin
                m_cnt = inc - m_cnt;
                wrap = (m_quad == 3);
                m_quad = (m_quad + 1) % 4;
            end else begin
                m_cnt = m_cnt - inc;
            end
            m_cyc = wrap;
            if (wrap && (m_pend || commit)) begin
                for (int i = 0; i < NPULSE; i++) m_active[i] = m_shadow[i];
                m_pend = 0;
                m_swp = 1;
            end else begin
                m_pend = m_pend | commit;
                m_swp = 0;
            end
            if (m_hold > 0) begin
                if (t2 == m_prior) begin m_pwm = m_prior; m_hold = 0; end
                else begin m_hold--; m_pwm = 0; end
            end else if (m_pwm != 0 && t2 != 0 && t2 != m_pwm && DEAD > 0) begin
                m_prior = m_pwm;
                m_pwm = 0;
                m_hold = DEAD - 1;
            end else begin
                m_pwm = t2;
            end
        end
        if (ang_we && int'(ang_addr) < NPULSE) m_shadow[ang_addr] = int'(ang_data);
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_edge();
    end

    // per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        check("pwm_drive", {30'd0, pwm_drive}, m_pwm);
        check("quadrant", {30'd0, quadrant}, m_quad);
        check("tri", {17'd0, tri_o}, int'(m_cnt >> (PHASE_W - TRI_W)));
        check("cycle_start", {31'd0, cycle_start}, {31'd0, m_cyc});
        check("bank_swapped", {31'd0, bank_swapped}, {31'd0, m_swp});
        checks++;
        if (pwm_drive === 2'b11) begin
            errors++;
            $display("FAIL pwm_11: got 3, required never 3 (t=%0t)", $time);
        end
        if (errors >= 40) finish_run();
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        edge_n += n;
    endtask

    task automatic step_to(input int e);
        step(e - edge_n);
    endtask

    task automatic write_ang(input int addr, input int data);
        ang_we = 1'b1; ang_addr = AW'(addr); ang_data = TRI_W'(data);
        step(1);
        ang_we = 1'b0;
    endtask

    int tbl [NPULSE] = '{4096, 8192, 12288, 16384, 16384};
    int w, w2, r, en_hold, len;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_pwm", {30'd0, pwm_drive}, 0);
        check("reset_quad", {30'd0, quadrant}, 0);
        check("reset_tri", {17'd0, tri_o}, 0);

        // all-zero bank: always on, so polarity reversal exercises the dead time
        en = 1'b1;
        increment = 18'h20000;
        edge_n = 0;
        step(2);    check("lag_off", {30'd0, pwm_drive}, 0);
        step(1);    check("lag_on", {30'd0, pwm_drive}, 2);
        step_to(1024);
        check("q1_at_1024", {30'd0, quadrant}, 1);
        check("tri_peak", {17'd0, tri_o}, 16384);
        step_to(2050); check("pos_before_rev", {30'd0, pwm_drive}, 2);
        step_to(2051); check("dead_first", {30'd0, pwm_drive}, 0);
        step_to(2070); check("dead_last", {30'd0, pwm_drive}, 0);
        step_to(2071); check("neg_after_dead", {30'd0, pwm_drive}, 1);

        for (int i = 0; i < NPULSE; i++) write_ang(i, tbl[i]);
        write_ang(7, 123);
        commit = 1'b1; step(1); commit = 1'b0;
        step_to(4095); check("no_cycle_early", {31'd0, cycle_start}, 0);
        step_to(4096);
        check("cycle_start_4096", {31'd0, cycle_start}, 1);
        check("swap_4096", {31'd0, bank_swapped}, 1);
        w = 4096;
        step_to(w + 258); check("tbl_off_4080", {30'd0, pwm_drive}, 0);
        step_to(w + 259); check("tbl_on_4096", {30'd0, pwm_drive}, 2);
        step_to(w + 514); check("tbl_on_8176", {30'd0, pwm_drive}, 2);
        step_to(w + 515); check("tbl_off_8192", {30'd0, pwm_drive}, 0);

        // mid-quadrant-1 rewrite: old table stays active until the next wrap
        step_to(w + 1500);
        write_ang(1, 6000);
        commit = 1'b1; step(1); commit = 1'b0;
        step_to(w + 3675); check("old_tbl_q3", {30'd0, pwm_drive}, 1);
        w2 = w + 4096;
        step_to(w2 - 1); check("no_swap_early", {31'd0, bank_swapped}, 0);
        step_to(w2);
        check("swap_2nd", {31'd0, bank_swapped}, 1);
        check("cycle_2nd", {31'd0, cycle_start}, 1);
        step_to(w2 + 303); check("new_tbl_on", {30'd0, pwm_drive}, 2);
        step_to(w2 + 427); check("new_tbl_off", {30'd0, pwm_drive}, 0);

        // pending commit survives an enable drop
        step_to(w2 + 500);
        write_ang(0, 0);
        commit = 1'b1; step(1); commit = 1'b0;
        step_to(w2 + 600);
        en = 1'b0;
        step(1);
        check("en_off_pwm", {30'd0, pwm_drive}, 0);
        check("en_off_quad", {30'd0, quadrant}, 0);
        check("en_off_tri", {17'd0, tri_o}, 0);
        step(4);
        en = 1'b1;
        r = edge_n;
        step_to(r + 1); check("restart_tri", {17'd0, tri_o}, 16);
        step_to(r + 4095); check("pend_no_swap", {31'd0, bank_swapped}, 0);
        step_to(r + 4096); check("pend_swap", {31'd0, bank_swapped}, 1);
        step_to(r + 4146); check("pre_rst_on", {30'd0, pwm_drive}, 2);

        // asynchronous reset takes effect without a clock edge
        #2 rst = 1'b1;
        #1;
        check("async_pwm", {30'd0, pwm_drive}, 0);
        check("async_quad", {30'd0, quadrant}, 0);
        check("async_tri", {17'd0, tri_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        edge_n = 0;
        step(1); check("post_rst_tri", {17'd0, tri_o}, 16);

        // randomized traffic, checked each cycle by the model
        en_hold = 0;
        for (int seg = 0; seg < 40; seg++) begin
            if ($urandom_range(0, 9) == 0) begin
                increment = '0;
                len = $urandom_range(20, 100);
            end else begin
                increment = INC_W'($urandom_range(32768, 262143));
                len = $urandom_range(200, 1200);
            end
            for (int c = 0; c < len; c++) begin
                ang_we   = ($urandom_range(0, 7) == 0);
                ang_addr = AW'($urandom_range(0, 7));
                ang_data = TRI_W'($urandom_range(0, 16384));
                commit   = ($urandom_range(0, 63) == 0);
                if (en_hold > 0) begin
                    en = 1'b0;
                    en_hold--;
                end else begin
                    en = 1'b1;
                    if ($urandom_range(0, 399) == 0) en_hold = $urandom_range(1, 6);
                end
                if (en && m_quad == 3 && m_cnt <= longint'(increment) && $urandom_range(0, 1) == 1) begin
                    commit = 1'b1;
                    ang_we = 1'b1;
                end
                step(1);
            end
        end
        ang_we = 1'b0;
        commit = 1'b0;
        step(2);
        finish_run();
    end

endmodule
